vermibus_arbiter: RTL and testbench
===================================

VERMIBUS_ARBITER -- requirements
Module: vermibus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive lost ibus arbitrations after which ibus wins (range 1..15).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_valid  input  1  instruction requester request.
REQ-005 SHALL have port i_address  input  32  instruction fetch address.
REQ-006 SHALL have port i_lookahead  input  32  predicted next fetch address.
REQ-007 SHALL have port i_ready  output  1  instruction access complete.
REQ-008 SHALL have port i_rdata  output  32  instruction read data.
REQ-009 SHALL have port d_valid  input  1  data requester request.
REQ-010 SHALL have port d_address  input  32  data address.
REQ-011 SHALL have port d_wstrobe  input  4  byte write enables; all 0 means load.
REQ-012 SHALL have port d_wdata  input  32  store data.
REQ-013 SHALL have port d_ready  output  1  data access complete.
REQ-014 SHALL have port d_rdata  output  32  load data.
REQ-015 SHALL have port d_irq  output  1  interrupt request to core.
REQ-016 SHALL have ports m_valid/m_address/m_lookahead/m_wstrobe/m_wdata  output  1/32/32/4/32  shared memory request.
REQ-017 SHALL have ports m_ready/m_rdata/m_irq  input  1/32/1  shared memory response.

Function
REQ-018 SHALL implement states IDLE, GRANT_I, GRANT_D in a registered state machine.
REQ-019 SHALL in IDLE drive m_valid=0, m_address=0, m_wstrobe=0, m_wdata=0, i_ready=0, d_ready=0.
REQ-020 SHALL in IDLE with any request select a winner and enter GRANT_I or GRANT_D at the next edge (1-cycle arbitration latency).
REQ-021 SHALL select the winner by fixed priority: d_valid beats i_valid, subject to REQ-033.
REQ-022 SHALL in GRANT_x drive m_valid=x_valid and drive m_address/m_wstrobe/m_wdata combinationally from the granted requester; m_wstrobe=0 and m_wdata=0 in GRANT_I.
REQ-023 SHALL drive m_lookahead = d_address in GRANT_D, else i_lookahead.
REQ-024 SHALL drive x_ready = m_ready only for the granted requester in the same cycle; the other ready is 0.
REQ-025 SHALL drive i_rdata and d_rdata = m_rdata unconditionally.
REQ-026 SHALL return to IDLE at the edge where m_valid && m_ready; minimum access time is 2 cycles, no back-to-back grant without an IDLE cycle.
REQ-027 SHALL, if the granted requester drops valid before m_ready, return to IDLE at the next edge without asserting its ready.
REQ-028 SHALL never change grant while m_valid=1 and m_ready=0 (no preemption).
REQ-029 SHALL drive d_irq = m_irq combinationally, independent of state.
REQ-030 SHALL treat simultaneous i_valid and d_valid in IDLE as one arbitration; the loser keeps waiting.

Reset
REQ-031 SHALL on reset asynchronously force state IDLE and starvation counter 0, so all outputs take REQ-019 values immediately, including mid-access.
REQ-032 SHALL resume arbitration at the first rising edge after reset deasserts.

Configuration
REQ-033 SHALL, when macro VERMIBUS_ARBITER_STARVE_EN is defined, keep a 4-bit counter incremented on each IDLE arbitration where both request and ibus loses, cleared when ibus is granted; when counter == STARVE_LIMIT, ibus wins.
REQ-034 SHALL, when VERMIBUS_ARBITER_STARVE_EN is undefined, contain no counter and apply pure dbus priority.

Verification
REQ-035 SHALL test: i_valid=1 only, i_address=0x100, m_ready=1 in 2nd cycle -> GRANT_I, m_address=0x100, i_ready=1 once, then IDLE.
REQ-036 SHALL test: i_valid and d_valid rise together, d_address=0x2000, d_wstrobe=0xF -> GRANT_D first with m_wstrobe=0xF, GRANT_I after an IDLE cycle.
REQ-037 SHALL test: m_ready held 0 for 5 cycles in GRANT_I while d_valid=1 -> m_address stays i_address, d_ready=0 throughout.
REQ-038 SHALL test: with STARVE_EN and STARVE_LIMIT=2, both requesting continuously -> grant order D,D,I,D,D,I; without macro -> D only until d_valid drops.
REQ-039 SHALL test: reset asserted mid-GRANT_D with m_ready=0 -> m_valid=0 and d_ready=0 in the same cycle, IDLE after release.
REQ-040 SHALL test: d_valid dropped in GRANT_D before m_ready -> d_ready never 1, IDLE at next edge; m_irq=1 -> d_irq=1 in all states.

Source files
------------

// File: rtl/vermibus_arbiter.sv
// Two-requester (ibus/dbus) arbiter sharing a single memory port; dbus has fixed priority.
// Optional ibus starvation guard is built in when VERMIBUS_ARBITER_STARVE_EN is defined.
module vermibus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_address,
  input  logic [31:0] i_lookahead,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_address,
  input  logic [3:0]  d_wstrobe,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_irq,
  output logic        m_valid,
  output logic [31:0] m_address,
  output logic [31:0] m_lookahead,
  output logic [3:0]  m_wstrobe,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  input  logic        m_irq
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;

  // Out-of-range limits are clamped so the 4-bit counter can always reach the threshold.
  localparam int unsigned LIMIT_CLAMP = (STARVE_LIMIT < 32'd1)  ? 32'd1  :
                                        (STARVE_LIMIT > 32'd15) ? 32'd15 : STARVE_LIMIT;
  localparam logic [3:0]  LIMIT_C     = LIMIT_CLAMP[3:0];

  logic [1:0] state_r;
  logic [1:0] state_next_s;
  logic       pick_i_s;
  logic       pick_d_s;
  logic       starve_win_s;

`ifdef VERMIBUS_ARBITER_STARVE_EN
  logic [3:0] starve_cnt_r;

  assign starve_win_s = i_valid && (starve_cnt_r == LIMIT_C);

  // Starvation counter: counts IDLE arbitrations ibus lost to dbus, cleared when ibus wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_r <= 4'd0;
    end else if (state_r == IDLE) begin
      if (pick_i_s) begin
        starve_cnt_r <= 4'd0;
      end else if (pick_d_s && i_valid) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end
    end
  end
`else
  logic [3:0] unused_limit_s;

  assign unused_limit_s = LIMIT_C;
  assign starve_win_s   = 1'b0;
`endif

  // Winner selection; only consumed while IDLE.
  always_comb begin
    pick_d_s = 1'b0;
    pick_i_s = 1'b0;
    if (d_valid && !starve_win_s) begin
      pick_d_s = 1'b1;
    end else if (i_valid) begin
      pick_i_s = 1'b1;
    end else begin
      pick_d_s = 1'b0;
      pick_i_s = 1'b0;
    end
  end

  // Next-state logic: a grant is held until handshake or until the requester withdraws.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_d_s) begin
          state_next_s = GRANT_D;
        end else if (pick_i_s) begin
          state_next_s = GRANT_I;
        end else begin
          state_next_s = IDLE;
        end
      end
      GRANT_I: begin
        if (!i_valid || m_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = GRANT_I;
        end
      end
      GRANT_D: begin
        if (!d_valid || m_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = GRANT_D;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Memory-side mux and ready routing; decoded straight from the state so reset clears them at once.
  always_comb begin
    m_valid     = 1'b0;
    m_address   = 32'd0;
    m_wstrobe   = 4'd0;
    m_wdata     = 32'd0;
    m_lookahead = i_lookahead;
    i_ready     = 1'b0;
    d_ready     = 1'b0;
    case (state_r)
      IDLE: begin
        m_valid = 1'b0;
      end
      GRANT_I: begin
        m_valid   = i_valid;
        m_address = i_address;
        i_ready   = i_valid & m_ready;
      end
      GRANT_D: begin
        m_valid     = d_valid;
        m_address   = d_address;
        m_wstrobe   = d_wstrobe;
        m_wdata     = d_wdata;
        m_lookahead = d_address;
        d_ready     = d_valid & m_ready;
      end
      default: begin
        m_valid = 1'b0;
      end
    endcase
  end

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign d_irq   = m_irq;

endmodule

// File: tb/tb_vermibus_arbiter.sv
// Scoreboard bench for vermibus_arbiter: directed corner cases plus randomized back-to-back traffic.
module tb_vermibus_arbiter;

  localparam int unsigned LIMIT = 2;
`ifdef VERMIBUS_ARBITER_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  typedef struct packed {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] look;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, d_valid, m_ready, m_irq;
  logic [31:0] i_address, i_lookahead, d_address, d_wdata, m_rdata;
  logic [3:0]  d_wstrobe;
  logic        i_ready, d_ready, d_irq, m_valid;
  logic [31:0] i_rdata, d_rdata, m_address, m_lookahead, m_wdata;
  logic [3:0]  m_wstrobe;

  int   vectors     = 0;
  int   miscompares = 0;
  bit   mon_en      = 1'b0;
  int   starve_m    = 0;
  txn_t exp_q[$];

  vermibus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_address(i_address), .i_lookahead(i_lookahead),
    .i_ready(i_ready), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_address(d_address), .d_wstrobe(d_wstrobe), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_irq(d_irq),
    .m_valid(m_valid), .m_address(m_address), .m_lookahead(m_lookahead),
    .m_wstrobe(m_wstrobe), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_irq(m_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every memory handshake must match the oldest predicted transaction.
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (mon_en && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_handshake: got address %h, expected no transaction", m_address);
        end else begin
          e = exp_q.pop_front();
          chk("sb_side", 32'({i_ready, d_ready}), e.is_d ? 32'd1 : 32'd2);
          chk("sb_addr", m_address, e.addr);
          chk("sb_look", m_lookahead, e.look);
          chk("sb_wstrb", 32'(m_wstrobe), 32'(e.wstrb));
          chk("sb_wdata", m_wdata, e.wdata);
          chk("sb_rdata", e.is_d ? d_rdata : i_rdata, m_rdata);
        end
      end
    end
  end

  // Both requesters issue their transactions back-to-back from the same start cycle.
  task automatic run_batch(input int ni, input int nd);
    txn_t iq[$];
    txn_t dq[$];
    txn_t t;
    int ci = 0;
    int cd = 0;
    int ii = 0;
    int di = 0;
    int guard = 0;
    logic hi, hd;
    for (int k = 0; k < ni; k++) begin
      t.is_d = 1'b0; t.addr = $urandom; t.look = $urandom; t.wstrb = 4'd0; t.wdata = 32'd0;
      iq.push_back(t);
    end
    for (int k = 0; k < nd; k++) begin
      t.is_d = 1'b1; t.addr = $urandom; t.look = t.addr;
      t.wstrb = 4'($urandom_range(0, 15)); t.wdata = $urandom;
      dq.push_back(t);
    end
    // Reference: dbus wins every contested round unless ibus has lost LIMIT rounds in a row.
    while (ci < ni || cd < nd) begin
      if (cd < nd && !(STARVE_ON && ci < ni && starve_m == int'(LIMIT))) begin
        exp_q.push_back(dq[cd]);
        cd++;
        if (ci < ni) starve_m++;
      end else begin
        exp_q.push_back(iq[ci]);
        ci++;
        starve_m = 0;
      end
    end
    while ((ii < ni || di < nd) && guard < 2000) begin
      i_valid = (ii < ni);
      if (ii < ni) begin i_address = iq[ii].addr; i_lookahead = iq[ii].look; end
      d_valid = (di < nd);
      if (di < nd) begin d_address = dq[di].addr; d_wstrobe = dq[di].wstrb; d_wdata = dq[di].wdata; end
      m_ready = 1'($urandom_range(0, 1));
      m_rdata = $urandom;
      m_irq   = 1'($urandom_range(0, 1));
      @(negedge clk);
      hi = i_ready;
      hd = d_ready;
      chk("irq_pass", 32'(d_irq), 32'(m_irq));
      next_cycle();
      if (hi) ii++;
      if (hd) di++;
      guard++;
    end
    if (guard >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL batch_timeout: got %0d/%0d accesses done, expected %0d/%0d", ii, di, ni, nd);
    end
    i_valid = 1'b0;
    d_valid = 1'b0;
    m_ready = 1'b0;
    repeat (3) next_cycle();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    i_valid = 1'b0; i_address = 32'd0; i_lookahead = 32'h0000_abcd;
    d_valid = 1'b0; d_address = 32'd0; d_wstrobe = 4'd0; d_wdata = 32'd0;
    m_ready = 1'b0; m_rdata = 32'd0; m_irq = 1'b0;
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_address", m_address, 32'd0);
    chk("rst_m_wstrobe", 32'(m_wstrobe), 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_readys", 32'({i_ready, d_ready}), 32'd0);
    chk("rst_lookahead", m_lookahead, 32'h0000_abcd);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single ibus access completing in its second cycle.
    i_valid = 1'b1; i_address = 32'h0000_0100; m_irq = 1'b1; m_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("t1_idle_m_valid", 32'(m_valid), 32'd0);
    next_cycle();
    m_ready = 1'b1;
    @(negedge clk);
    chk("t1_m_valid", 32'(m_valid), 32'd1);
    chk("t1_m_address", m_address, 32'h0000_0100);
    chk("t1_m_wstrobe", 32'(m_wstrobe), 32'd0);
    chk("t1_readys", 32'({i_ready, d_ready}), 32'd2);
    chk("t1_i_rdata", i_rdata, 32'h1234_5678);
    chk("t1_d_rdata", d_rdata, 32'h1234_5678);
    chk("t1_irq_grant_i", 32'(d_irq), 32'd1);
    next_cycle();
    i_valid = 1'b0; m_ready = 1'b0; m_irq = 1'b0;
    @(negedge clk);
    chk("t1_back_idle", 32'({m_valid, i_ready}), 32'd0);
    chk("t1_irq_low", 32'(d_irq), 32'd0);
    next_cycle();

    // Simultaneous requests: dbus first, ibus after an IDLE cycle.
    i_valid = 1'b1; i_address = 32'h0000_0300;
    d_valid = 1'b1; d_address = 32'h0000_2000; d_wstrobe = 4'hf; d_wdata = 32'hcafe_f00d;
    m_ready = 1'b1;
    @(negedge clk);
    chk("t2_idle_m_valid", 32'(m_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t2_d_address", m_address, 32'h0000_2000);
    chk("t2_d_wstrobe", 32'(m_wstrobe), 32'hf);
    chk("t2_d_wdata", m_wdata, 32'hcafe_f00d);
    chk("t2_d_look", m_lookahead, 32'h0000_2000);
    chk("t2_d_readys", 32'({i_ready, d_ready}), 32'd1);
    next_cycle();
    d_valid = 1'b0;
    @(negedge clk);
    chk("t2_gap_idle", 32'({m_valid, i_ready, d_ready}), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t2_i_address", m_address, 32'h0000_0300);
    chk("t2_i_wstrobe", 32'(m_wstrobe), 32'd0);
    chk("t2_i_readys", 32'({i_ready, d_ready}), 32'd2);
    next_cycle();
    i_valid = 1'b0; m_ready = 1'b0;
    next_cycle();

    // Stalled ibus grant must not be preempted by a later dbus request.
    i_valid = 1'b1; i_address = 32'h0000_0400;
    next_cycle();
    d_valid = 1'b1; d_address = 32'h0000_5000; d_wstrobe = 4'h3; d_wdata = 32'h0bad_beef;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_hold_address", m_address, 32'h0000_0400);
      chk("t3_hold_readys", 32'({m_valid, i_ready, d_ready}), 32'd4);
      next_cycle();
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("t3_i_done", 32'({i_ready, d_ready}), 32'd2);
    next_cycle();
    i_valid = 1'b0; m_ready = 1'b0;
    next_cycle();

    // Reset in the middle of a stalled dbus grant.
    @(negedge clk);
    chk("t4_grant_d", m_address, 32'h0000_5000);
    #2 reset = 1'b1;
    #1;
    chk("t4_rst_m_valid", 32'(m_valid), 32'd0);
    chk("t4_rst_outs", m_address | m_wdata | 32'(m_wstrobe) | 32'(d_ready), 32'd0);
    m_ready = 1'b1;
    #1;
    chk("t4_rst_d_ready", 32'(d_ready), 32'd0);
    m_ready = 1'b0;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("t4_idle_after", 32'(m_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t4_regrant", 32'({m_valid, d_ready}), 32'd2);

    // dbus withdraws before m_ready; grant must lapse to IDLE at the next edge.
    m_irq = 1'b1;
    next_cycle();
    d_valid = 1'b0;
    @(negedge clk);
    chk("t5_drop_outs", 32'({m_valid, d_ready}), 32'd0);
    chk("t5_drop_look", m_lookahead, 32'h0000_5000);
    chk("t5_irq_grant_d", 32'(d_irq), 32'd1);
    next_cycle();
    m_ready = 1'b1;
    @(negedge clk);
    chk("t5_idle_look", m_lookahead, 32'h0000_abcd);
    chk("t5_idle_d_ready", 32'({m_valid, d_ready}), 32'd0);
    chk("t5_irq_idle", 32'(d_irq), 32'd1);
    next_cycle();
    m_ready = 1'b0; m_irq = 1'b0;
    next_cycle();

    // Randomized contention through the scoreboard; first batch exercises the starvation order.
    mon_en = 1'b1;
    starve_m = 0;
    run_batch(3, 6);
    for (int b = 0; b < 25; b++) begin
      run_batch($urandom_range(0, 5), $urandom_range(0, 5));
    end
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
